// File: rtl/ixc_readback_pkg.sv
// rtl/ixc_readback_pkg.sv - shared types and sizing helpers for the snapshot readback block
package ixc_readback_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Beats needed to carry a width-bit vector in chunk-bit pieces.
  function automatic int nbeats(input int width, input int chunk);
    return (width + chunk - 1) / chunk;
  endfunction

  // Beat counter width; a single-beat stream still needs a 1-bit counter.
  function automatic int beat_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int NBEATS_DEF = nbeats(22, 8);
  localparam int BEAT_W_DEF = beat_w(NBEATS_DEF);

endpackage

// File: rtl/ixc_readback_22.sv
// rtl/ixc_readback_22.sv - captures a probed vector on request and streams it as LSB-first beats
module ixc_readback_22
  import ixc_readback_pkg::*;
#(
  parameter int WIDTH = 22,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] probe,
  input  logic             snap_req,
  input  logic             ovr_clr,
  output logic             snap_busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CHUNK-1:0] out_data,
  output logic             out_last,
  output logic             overrun
);

  localparam int NBEATS = nbeats(WIDTH, CHUNK);
  localparam int BEAT_W = beat_w(NBEATS);
  localparam int PAD_W  = NBEATS * CHUNK;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);

  state_t             state_q, state_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic [WIDTH-1:0]   shadow_q, shadow_d;
  logic               overrun_q, overrun_d;
  logic [PAD_W-1:0]   padded;
  logic               hs;
  logic               last_hs;
  logic               drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      shadow_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      shadow_q  <= shadow_d;
      overrun_q <= overrun_d;
    end
  end

  // Upper bits of the final beat come from the zero padding, never from stale data.
  always_comb begin
    padded = '0;
    padded[WIDTH-1:0] = shadow_q;
  end

  assign out_valid = (state_q == SEND);
  assign snap_busy = (state_q == SEND);
  assign out_last  = (state_q == SEND) && (beat_q == LAST_BEAT);
  assign out_data  = (state_q == SEND) ? padded[int'(beat_q) * CHUNK +: CHUNK] : '0;
  assign overrun   = overrun_q;

  assign hs      = out_valid & out_ready;
  assign last_hs = hs & out_last;

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    shadow_d  = shadow_q;
    overrun_d = overrun_q;
    drop      = 1'b0;

    case (state_q)
      IDLE: begin
        if (snap_req) begin
          shadow_d = probe;
          beat_d   = '0;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (last_hs) begin
          // A request on the closing handshake chains straight into a new snapshot.
          if (snap_req) begin
            shadow_d = probe;
            beat_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (hs) begin
            beat_d = beat_q + 1'b1;
          end
          drop = snap_req;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (ovr_clr) begin
      overrun_d = 1'b0;
    end
    if (drop) begin
      overrun_d = 1'b1;
    end
  end

endmodule

// File: tb/tb_ixc_readback_22.sv
// tb/tb_ixc_readback_22.sv - self-checking bench for ixc_readback_22
module tb_ixc_readback_22;

  localparam int WIDTH  = 22;
  localparam int CHUNK  = 8;
  localparam int NBEATS = 3;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] probe;
  logic             snap_req;
  logic             ovr_clr;
  logic             snap_busy;
  logic             out_valid;
  logic             out_ready;
  logic [CHUNK-1:0] out_data;
  logic             out_last;
  logic             overrun;

  int errors = 0;
  int checks = 0;
  int hs_count = 0;

  // Reference: queue of beats still owed to the collector, plus the sticky flag.
  logic [CHUNK-1:0] exp_q[$];
  logic             m_ovr;

  ixc_readback_22 #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .probe     (probe),
    .snap_req  (snap_req),
    .ovr_clr   (ovr_clr),
    .snap_busy (snap_busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic       v;
    logic [7:0] d;
    v = (exp_q.size() != 0);
    d = v ? exp_q[0] : 8'h00;
    chk({tag, ".valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".busy"},  32'(snap_busy), 32'(v));
    chk({tag, ".data"},  32'(out_data),  32'(d));
    chk({tag, ".last"},  32'(out_last),  32'(v && exp_q.size() == 1));
    chk({tag, ".ovr"},   32'(overrun),   32'(m_ovr));
  endtask

  task automatic push_snapshot(input logic [WIDTH-1:0] p);
    logic [31:0] v;
    v = 32'(p);
    for (int i = 0; i < NBEATS; i++) begin
      exp_q.push_back(8'((v / (32'd1 << (8 * i))) % 32'd256));
    end
  endtask

  // Called just after a falling edge: check, drive, advance model, cross the next rising edge.
  task automatic cyc(input string tag, input logic s, input logic r,
                     input logic [WIDTH-1:0] p, input logic c);
    logic valid, hs, last_hs, dropped;
    check_outputs(tag);
    snap_req  = s;
    out_ready = r;
    probe     = p;
    ovr_clr   = c;
    valid   = (exp_q.size() != 0);
    hs      = valid && r;
    last_hs = hs && exp_q.size() == 1;
    dropped = 1'b0;
    if (hs) begin
      void'(exp_q.pop_front());
      hs_count++;
    end
    if (s) begin
      if (!valid || last_hs) push_snapshot(p);
      else dropped = 1'b1;
    end
    if (c) m_ovr = 1'b0;
    if (dropped) m_ovr = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int h0;
    rst_n = 1'b0; probe = '0; snap_req = 1'b0; ovr_clr = 1'b0; out_ready = 1'b0;
    m_ovr = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cyc("reset", 1'b0, 1'b1, '0, 1'b0);

    // Basic snapshot
    cyc("basic_req", 1'b1, 1'b1, 22'h2A5F3C, 1'b0);
    chk("basic_b0_const", 32'(out_data), 32'h3C);
    cyc("basic_b0", 1'b0, 1'b1, 22'h2A5F3C, 1'b0);
    chk("basic_b1_const", 32'(out_data), 32'h5F);
    cyc("basic_b1", 1'b0, 1'b1, 22'h2A5F3C, 1'b0);
    chk("basic_b2_const", 32'(out_data), 32'h2A);
    chk("basic_b2_last", 32'(out_last), 32'h1);
    cyc("basic_b2", 1'b0, 1'b1, 22'h2A5F3C, 1'b0);
    cyc("basic_idle", 1'b0, 1'b1, 22'h2A5F3C, 1'b0);

    // Capture isolation: probe drops to 0 while streaming
    cyc("iso_req", 1'b1, 1'b1, 22'h3FFFFF, 1'b0);
    cyc("iso_b0", 1'b0, 1'b1, '0, 1'b0);
    cyc("iso_b1", 1'b0, 1'b1, '0, 1'b0);
    chk("iso_pad_const", 32'(out_data), 32'h3F);
    cyc("iso_b2", 1'b0, 1'b1, '0, 1'b0);
    cyc("iso_idle", 1'b0, 1'b1, '0, 1'b0);

    // Backpressure on beat 1
    h0 = hs_count;
    cyc("bp_req", 1'b1, 1'b1, 22'h2A5F3C, 1'b0);
    cyc("bp_b0", 1'b0, 1'b1, '0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_const", 32'(out_data), 32'h5F);
      cyc("bp_stall", 1'b0, 1'b0, 22'(i), 1'b0);
    end
    cyc("bp_b1", 1'b0, 1'b1, '0, 1'b0);
    cyc("bp_b2", 1'b0, 1'b1, '0, 1'b0);
    cyc("bp_idle", 1'b0, 1'b1, '0, 1'b0);
    chk("bp_handshakes", 32'(hs_count - h0), 32'd3);

    // Overrun, back-to-back, clear
    cyc("ov_req", 1'b1, 1'b1, 22'h2A5F3C, 1'b0);
    cyc("ov_b0", 1'b0, 1'b1, '0, 1'b0);
    cyc("ov_drop", 1'b1, 1'b1, 22'h155555, 1'b0);
    chk("ov_set_const", 32'(overrun), 32'h1);
    chk("ov_b2_const", 32'(out_data), 32'h2A);
    cyc("ov_b2b", 1'b1, 1'b1, 22'h000123, 1'b0);
    chk("b2b_valid_const", 32'(out_valid), 32'h1);
    chk("b2b_b0_const", 32'(out_data), 32'h23);
    cyc("b2b_b0", 1'b0, 1'b1, '0, 1'b0);
    cyc("b2b_b1", 1'b1, 1'b0, '0, 1'b1);
    chk("ov_setwins_const", 32'(overrun), 32'h1);
    cyc("b2b_b2", 1'b0, 1'b1, '0, 1'b0);
    cyc("ov_clr", 1'b0, 1'b1, '0, 1'b1);
    chk("ov_clr_const", 32'(overrun), 32'h0);

    // Reset mid-stream with overrun set
    cyc("rst_req", 1'b1, 1'b1, 22'h2A5F3C, 1'b0);
    cyc("rst_drop", 1'b1, 1'b1, 22'h0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_last", 32'(out_last), 32'h0);
    chk("rst_ovr", 32'(overrun), 32'h0);
    chk("rst_busy", 32'(snap_busy), 32'h0);
    exp_q.delete();
    m_ovr = 1'b0;
    snap_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc("post_rst", 1'b0, 1'b1, '0, 1'b0);
    cyc("post_req", 1'b1, 1'b1, 22'h0ABCDE, 1'b0);
    chk("post_b0_const", 32'(out_data), 32'hDE);
    for (int i = 0; i < 4; i++) cyc("post_run", 1'b0, 1'b1, '0, 1'b0);

    // Randomized traffic against the queue model
    for (int i = 0; i < 400; i++) begin
      cyc("rand",
          ($urandom_range(3) == 0),
          ($urandom_range(3) != 0),
          WIDTH'($urandom),
          ($urandom_range(15) == 0));
    end
    check_outputs("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ixc_readback_22.md
# ixc_readback_22

Snapshot readback block for the emulation template library. It is the reverse path of the per-bit assign templates: instead of driving a 22-bit net from a source, it captures a 22-bit probed net on request. It then streams the captured value to the host-side readback channel as fixed-width beats over a valid/ready handshake. One instance sits beside each probed vector; beats are consumed by the readback collector.

## Interface
- WIDTH, 22, probed vector width; must be ≥ 1.
- CHUNK, 8, output beat width; must be ≥ 1.
- NBEATS (localparam), ceil(WIDTH/CHUNK) = 3 at defaults.

- clk  in  1  single clock; every register in the block is on its rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- probe  in  WIDTH  probed net; sampled only on accepted snapshot.
- snap_req  in  1  one-cycle snapshot request pulse.
- ovr_clr  in  1  clears the overrun flag.
- snap_busy  out  1  high while a snapshot is being streamed.
- out_valid  out  1  beat available.
- out_ready  in  1  collector accepts the beat.
- out_data  out  CHUNK  current beat, LSB chunk first.
- out_last  out  1  high with the final beat of a snapshot.
- overrun  out  1  sticky; a snap_req was dropped.

## Operation
- Two states: IDLE and SEND. Reset state is IDLE.
- IDLE with snap_req=1: shadow ← probe, beat ← 0, go to SEND.
- SEND: out_valid=1 and out_data=shadow[beat*CHUNK +: CHUNK]. Bits of the final beat above WIDTH-1 read 0.
- out_last = (beat == NBEATS-1) while in SEND.
- A handshake is out_valid & out_ready. On a handshake that is not the last beat, beat increments.
- On the last-beat handshake:
  - if snap_req=1 in the same cycle: recapture probe, beat ← 0, stay in SEND (back-to-back snapshot, no bubble);
  - otherwise go to IDLE.
- snap_req in SEND, other than on the last-beat handshake: the request is dropped and overrun ← 1. The shadow and beat are untouched.
- overrun is cleared by ovr_clr=1. If ovr_clr and a drop occur in the same cycle, set wins.
- Once out_valid is asserted, out_data, out_last and out_valid hold stable until the handshake, regardless of probe changes.
- snap_busy = (state == SEND).
- Reset values: state IDLE, beat 0, shadow 0, out_valid 0, out_last 0, out_data 0, snap_busy 0, overrun 0.

## Timing
- snap_req sampled at edge t: probe is captured at t. out_valid and snap_busy are high from t+1, with beat 0 on out_data.
- Minimum snapshot duration is NBEATS cycles when out_ready is held high. At defaults that is 3 cycles: t+1, t+2, t+3.
- Last-beat handshake at edge u without a new request: out_valid=0 and snap_busy=0 from u+1. A new snap_req is accepted at u+1 or later.
- Last-beat handshake at u with snap_req: beat 0 of the new snapshot is presented from u+1; out_valid stays high.
- out_ready low stalls indefinitely with no timeout. The held beat is never lost or duplicated.
- rst_n asserted mid-snapshot immediately drops out_valid and out_last and discards the snapshot. No partial completion is signalled.
- Release of rst_n is synchronized externally; the block requires no snap_req in the first cycle after release.

## Structure
- Package ixc_readback_pkg holds:
  - the state enum {IDLE, SEND};
  - the function nbeats(width, chunk) for ceil division;
  - the beat-counter width, $clog2(NBEATS) with a minimum of 1.
- Single module. No sub-module: beat selection is an indexed part-select on the zero-padded shadow, of width NBEATS*CHUNK.

## Test plan
- Basic snapshot: probe=22'h2A5F3C, snap_req pulse, out_ready=1 → beats 0x3C, 0x5F, 0x2A on three consecutive cycles; out_last only on 0x2A; idle afterwards.
- Capture isolation: snapshot of 22'h3FFFFF, then probe changes to 0 during streaming → beats remain 0xFF, 0xFF, 0x3F; the padding bits of the last beat are 0.
- Backpressure: out_ready low for 5 cycles on beat 1 → out_data holds 0x5F and out_valid stays high; beat 2 follows the first ready cycle; exactly 3 handshakes total.
- Overrun and back-to-back:
  - snap_req in the cycle beat 1 is presented → overrun=1, stream unchanged;
  - snap_req on the last-beat handshake with probe=22'h000123 → next beats 0x23, 0x01, 0x00 with no bubble;
  - ovr_clr → overrun=0.
- Reset mid-stream: rst_n low during beat 1 → out_valid=0 and overrun=0 immediately; after release a new snapshot streams correctly from beat 0.
